// File: rtl/helios_stream_arbiter_if.sv
// Channel-side and core-side byte handshakes of the Helios stream arbiter.
// master is the arbiter's view; slave is the surrounding channels and core.
interface helios_stream_arbiter_if #(
  parameter int NUM_CHANNELS = 4
);
  logic [8*NUM_CHANNELS-1:0] ch_in_data;
  logic [NUM_CHANNELS-1:0]   ch_in_valid;
  logic [NUM_CHANNELS-1:0]   ch_in_ready;
  logic [7:0]                ch_out_data;
  logic [NUM_CHANNELS-1:0]   ch_out_valid;
  logic [NUM_CHANNELS-1:0]   ch_out_ready;
  logic [7:0]                core_input_data;
  logic                      core_input_valid;
  logic                      core_input_ready;
  logic [7:0]                core_output_data;
  logic                      core_output_valid;
  logic                      core_output_ready;

  modport master (
    input  ch_in_data, ch_in_valid, ch_out_ready,
    input  core_input_ready, core_output_data, core_output_valid,
    output ch_in_ready, ch_out_data, ch_out_valid,
    output core_input_data, core_input_valid, core_output_ready
  );

  modport slave (
    output ch_in_data, ch_in_valid, ch_out_ready,
    output core_input_ready, core_output_data, core_output_valid,
    input  ch_in_ready, ch_out_data, ch_out_valid,
    input  core_input_data, core_input_valid, core_output_ready
  );
endinterface

// File: rtl/helios_stream_arbiter.sv
// Round-robin time-sharing of one decoder core between byte-stream channels:
// one whole job in, its whole result out, then re-arbitrate.
module helios_stream_arbiter #(
  parameter int  NUM_CHANNELS  = 4,
  parameter int  JOB_IN_BYTES  = 4,
  parameter int  JOB_OUT_BYTES = 2,
  localparam int CH_W      = $clog2(NUM_CHANNELS),
  localparam int MAX_BYTES = (JOB_IN_BYTES > JOB_OUT_BYTES) ? JOB_IN_BYTES : JOB_OUT_BYTES,
  localparam int CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  helios_stream_arbiter_if.master bus,
  output logic [CH_W-1:0]         grant,
  output logic                    busy,
  output logic [15:0]             jobs_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(JOB_IN_BYTES - 1);
  localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(JOB_OUT_BYTES - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CHANNELS - 1);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]   last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       jobs_done_q, jobs_done_d;

  logic [CH_W-1:0]   pick_ch;
  logic [CH_W-1:0]   cand;
  logic              pick_found;
  logic              gnt_in_valid;
  logic              gnt_out_ready;
  logic              in_hs;
  logic              out_hs;

  assign gnt_in_valid  = bus.ch_in_valid[grant_q];
  assign gnt_out_ready = bus.ch_out_ready[grant_q];
  assign in_hs  = (state_q == FEED)  && gnt_in_valid && bus.core_input_ready;
  assign out_hs = (state_q == DRAIN) && bus.core_output_valid && gnt_out_ready;

  // Search starts just after the last served channel, so it rotates priority.
  always_comb begin
    pick_found = 1'b0;
    pick_ch    = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_CHANNELS; k++) begin
      cand = CH_W'((int'(last_grant_q) + k) % NUM_CHANNELS);
      if (!pick_found && bus.ch_in_valid[cand]) begin
        pick_found = 1'b1;
        pick_ch    = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_CH;
      cnt_q        <= '0;
      jobs_done_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      jobs_done_q  <= jobs_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    jobs_done_d  = jobs_done_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_ch;
          cnt_d   = '0;
          state_d = FEED;
        end
      end
      FEED: begin
        if (in_hs) begin
          if (cnt_q == IN_LAST) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (out_hs) begin
          if (cnt_q == OUT_LAST) begin
            cnt_d        = '0;
            last_grant_d = grant_q;
            jobs_done_d  = jobs_done_q + 16'd1;
            state_d      = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Core output is never accepted during FEED; the core holds it until DRAIN.
  always_comb begin
    bus.ch_in_ready       = '0;
    bus.ch_out_valid      = '0;
    bus.ch_out_data       = bus.core_output_data;
    bus.core_input_data   = bus.ch_in_data[{grant_q, 3'b000} +: 8];
    bus.core_input_valid  = 1'b0;
    bus.core_output_ready = 1'b0;
    case (state_q)
      FEED: begin
        bus.core_input_valid     = gnt_in_valid;
        bus.ch_in_ready[grant_q] = bus.core_input_ready;
      end
      DRAIN: begin
        bus.ch_out_valid[grant_q] = bus.core_output_valid;
        bus.core_output_ready     = gnt_out_ready;
      end
      default: ;
    endcase
  end

  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);
  assign jobs_done = jobs_done_q;

endmodule
